// File: rtl/router_out_deser.sv
// router_out_deser: per-port serial-to-byte deserializer behind the 16x16 router.
// Collects LSB-first payload bits into bytes and queues them, each with an
// end-of-packet flag, in a first-word-fall-through FIFO. The consumer reads
// the FIFO through a byte-wide valid/ready interface.
// Optional build: define ROUTER_DESER_STATS_EN to add saturating packet and drop
// counters. Without it, pkt_cnt_o and drop_cnt_o are tied to zero.
module router_out_deser #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          dout,
   input  logic                          frameo_n,
   input  logic                          valido_n,
   output logic [7:0]                    byte_o,
   output logic                          byte_last_o,
   output logic                          byte_valid_o,
   input  logic                          byte_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   input  logic                          err_clr_i,
   output logic                          err_frag_o,
   output logic                          err_ovf_o,
   output logic [CNT_W-1:0]              pkt_cnt_o,
   output logic [CNT_W-1:0]              drop_cnt_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_COLLECT, S_DROP} state_t;

   state_t          state_q, state_d;
   logic [7:0]      sr_q, sr_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [LW-1:0]   level_q, level_d;
   logic [8:0]      mem_q [FIFO_DEPTH];
   logic            err_frag_q, err_ovf_q;

   logic            shift_en, push_req, frag_set;
   logic            push_ok, ovf, pop;
   logic [7:0]      push_byte;
   logic            push_last;

   // The completing bit goes straight into the pushed byte; it never lands in sr_q.
   assign push_byte = {dout, sr_q[6:0]};
   assign push_last = frameo_n;

   assign byte_valid_o = (level_q != '0);
   assign pop          = byte_valid_o & byte_ready_i;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push_ok      = push_req & ((level_q != LW'(FIFO_DEPTH)) | pop);
   assign ovf          = push_req & ~push_ok;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_SYNC;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SYNC:    if (frameo_n) state_d = S_IDLE;
         S_IDLE:    if (!frameo_n && !valido_n) state_d = S_COLLECT;
         S_COLLECT: begin
            if (!valido_n) begin
               if (bitcnt_q == 3'd7) begin
                  if (frameo_n)     state_d = S_IDLE;
                  else if (!push_ok) state_d = S_DROP;
               end else if (frameo_n) begin
                  state_d = S_IDLE;
               end
            end else if (frameo_n) begin
               state_d = S_IDLE;
            end
         end
         S_DROP:    if (frameo_n) state_d = S_IDLE;
         default:   state_d = S_SYNC;
      endcase
   end

   // FSM outputs: shift, push request and fragment detection
   always_comb begin
      shift_en = 1'b0;
      push_req = 1'b0;
      frag_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!valido_n) begin
               // A single valid bit that also ends the frame is a fragment.
               if (!frameo_n) shift_en = 1'b1;
               else           frag_set = 1'b1;
            end
         end
         S_COLLECT: begin
            if (!valido_n) begin
               if (bitcnt_q == 3'd7) push_req = 1'b1;
               else if (frameo_n)    frag_set = 1'b1;
               else                  shift_en = 1'b1;
            end else if (frameo_n && (bitcnt_q != 3'd0)) begin
               frag_set = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Shift register and bit counter; DROP keeps counting so byte boundaries stay known
   always_comb begin
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
      if (shift_en) sr_d[bitcnt_q] = dout;
      if (shift_en || push_req || ((state_q == S_DROP) && !valido_n))
         bitcnt_d = bitcnt_q + 3'd1;
      if ((state_d == S_IDLE) || (state_d == S_SYNC))
         bitcnt_d = 3'd0;
   end

   // Datapath registers for bit collection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sr_q     <= 8'd0;
         bitcnt_q <= 3'd0;
      end else begin
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   // FIFO occupancy follows push and pop; simultaneous push and pop leave it unchanged
   always_comb begin
      level_d = level_q + LW'(push_ok) - LW'(pop);
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // FIFO storage: {last, byte} per entry
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= {push_last, push_byte};
   end

   assign byte_o      = byte_valid_o ? mem_q[rptr_q][7:0] : 8'd0;
   assign byte_last_o = byte_valid_o ? mem_q[rptr_q][8]   : 1'b0;
   assign level_o     = level_q;

   // Sticky error flags; a fresh error wins over a clear in the same cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_frag_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         err_frag_q <= (err_frag_q & ~err_clr_i) | frag_set;
         err_ovf_q  <= (err_ovf_q  & ~err_clr_i) | ovf;
      end
   end

   assign err_frag_o = err_frag_q;
   assign err_ovf_o  = err_ovf_q;

`ifdef ROUTER_DESER_STATS_EN
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
   logic             drop_byte;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Each byte boundary passed while discarding counts as one more dropped byte.
   assign drop_byte = (state_q == S_DROP) && !valido_n && (bitcnt_q == 3'd7);

   // Counter next-state with saturation
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (push_ok && push_last) pkt_cnt_d  = sat_inc(pkt_cnt_q);
      if (ovf || drop_byte)     drop_cnt_d = sat_inc(drop_cnt_q);
   end

   // Statistics counter registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign pkt_cnt_o  = pkt_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`else
   assign pkt_cnt_o  = '0;
   assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_router_out_deser.sv
// Testbench for router_out_deser: directed scenarios plus randomized packets
// checked against a packet-level model (queues of expected {last, byte}).
module tb_router_out_deser;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;
`ifdef ROUTER_DESER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n, dout, frameo_n, valido_n, byte_ready_i, err_clr_i;
   logic [7:0]       byte_o;
   logic             byte_last_o, byte_valid_o, err_frag_o, err_ovf_o;
   logic [4:0]       level_o;
   logic [CNT_W-1:0] pkt_cnt_o, drop_cnt_o;

   int n_cmp = 0;
   int n_err = 0;
   int exp_pkt = 0;
   int exp_drop = 0;
   int ready_mode = 0;   // 0 low, 1 high, 2 random, 3 one-cycle pulse
   logic [8:0] rxq[$];
   logic [8:0] expq[$];

   router_out_deser #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .dout(dout), .frameo_n(frameo_n),
      .valido_n(valido_n), .byte_o(byte_o), .byte_last_o(byte_last_o),
      .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
      .level_o(level_o), .err_clr_i(err_clr_i), .err_frag_o(err_frag_o),
      .err_ovf_o(err_ovf_o), .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk = ~clk;

   // Consumer: drive ready on the falling edge and record every byte that will be popped.
   always @(negedge clk) begin
      case (ready_mode)
         1:       byte_ready_i = 1'b1;
         2:       byte_ready_i = 1'($urandom_range(0, 1));
         3:       begin byte_ready_i = 1'b1; ready_mode = 0; end
         default: byte_ready_i = 1'b0;
      endcase
      if (byte_valid_o === 1'b1 && byte_ready_i === 1'b1)
         rxq.push_back({byte_last_o, byte_o});
   end

   function automatic logic [CNT_W-1:0] exp_cnt(input int v);
      return STATS ? CNT_W'(v) : '0;
   endfunction

   task automatic drive_bit(input logic f, input logic v, input logic d);
      @(negedge clk);
      frameo_n = f;
      valido_n = v;
      dout     = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_bit(1'b1, 1'b1, 1'b0);
   endtask

   // bub[i] inserts one bubble cycle after bit i
   task automatic send_packet(input logic [159:0] data, input int nbits, input logic [159:0] bub);
      for (int i = 0; i < nbits; i++) begin
         drive_bit((i == nbits - 1), 1'b0, data[i]);
         if (bub[i] && (i != nbits - 1)) drive_bit(1'b0, 1'b1, 1'b0);
      end
      drive_bit(1'b1, 1'b1, 1'b0);
   endtask

   task automatic pulse_clr();
      @(negedge clk); err_clr_i = 1'b1;
      @(negedge clk); err_clr_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; frameo_n = 1'b1; valido_n = 1'b1; dout = 1'b0;
      err_clr_i = 1'b0; ready_mode = 0; byte_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({byte_o, byte_last_o, byte_valid_o, level_o, err_frag_o, err_ovf_o} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_outputs: byte=%h last=%b valid=%b level=%0d frag=%b ovf=%b, want all 0",
                  byte_o, byte_last_o, byte_valid_o, level_o, err_frag_o, err_ovf_o);
      end
      n_cmp++;
      if ({pkt_cnt_o, drop_cnt_o} !== '0) begin
         n_err++;
         $display("FAIL reset_counters: pkt=%0d drop=%0d, want 0", pkt_cnt_o, drop_cnt_o);
      end
      reset_n = 1'b1;
      exp_pkt = 0; exp_drop = 0;
      idle(2);
   endtask

   task automatic test_basic(input logic [159:0] bub, input string nm);
      rxq.delete();
      ready_mode = 1;
      send_packet(160'h3CA5, 16, bub);
      idle(4);
      exp_pkt++;
      n_cmp++;
      if (rxq.size() != 2 || rxq[0] !== 9'h0A5 || rxq[1] !== 9'h13C) begin
         n_err++;
         $display("FAIL %s_bytes: got n=%0d first=%h second=%h, want n=2 0a5 13c",
                  nm, rxq.size(), rxq[0], rxq[1]);
      end
      n_cmp++;
      if ({err_frag_o, err_ovf_o} !== 2'b00) begin
         n_err++;
         $display("FAIL %s_errors: frag=%b ovf=%b, want 0 0", nm, err_frag_o, err_ovf_o);
      end
      n_cmp++;
      if (pkt_cnt_o !== exp_cnt(exp_pkt)) begin
         n_err++;
         $display("FAIL %s_pkt_cnt: got %0d want %0d", nm, pkt_cnt_o, exp_cnt(exp_pkt));
      end
      ready_mode = 0;
   endtask

   task automatic test_frag();
      rxq.delete();
      ready_mode = 0;
      send_packet(160'hABC, 12, 160'd0);
      idle(2);
      n_cmp++;
      if (level_o !== 5'd1 || err_frag_o !== 1'b1 || err_ovf_o !== 1'b0) begin
         n_err++;
         $display("FAIL frag_state: level=%0d frag=%b ovf=%b, want 1 1 0", level_o, err_frag_o, err_ovf_o);
      end
      ready_mode = 1;
      idle(3);
      n_cmp++;
      if (rxq.size() != 1 || rxq[0] !== 9'h0BC) begin
         n_err++;
         $display("FAIL frag_byte: got n=%0d byte=%h, want n=1 0bc", rxq.size(), rxq[0]);
      end
      ready_mode = 0;
      pulse_clr();
      n_cmp++;
      if (err_frag_o !== 1'b0) begin
         n_err++;
         $display("FAIL frag_clear: got %b want 0", err_frag_o);
      end
      n_cmp++;
      if (pkt_cnt_o !== exp_cnt(exp_pkt)) begin
         n_err++;
         $display("FAIL frag_pkt_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt(exp_pkt));
      end
   endtask

   task automatic test_overflow();
      logic [159:0] data;
      data = '0;
      for (int i = 0; i < DEPTH + 2; i++) data[i*8 +: 8] = 8'($urandom);
      rxq.delete();
      ready_mode = 0;
      send_packet(data, (DEPTH + 2) * 8, 160'd0);
      idle(2);
      exp_drop += 2;
      n_cmp++;
      if (level_o !== 5'(DEPTH) || err_ovf_o !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_state: level=%0d ovf=%b, want %0d 1", level_o, err_ovf_o, DEPTH);
      end
      n_cmp++;
      if (drop_cnt_o !== exp_cnt(exp_drop)) begin
         n_err++;
         $display("FAIL ovf_drop_cnt: got %0d want %0d", drop_cnt_o, exp_cnt(exp_drop));
      end
      ready_mode = 1;
      idle(DEPTH + 4);
      n_cmp++;
      if (rxq.size() != DEPTH || level_o !== 5'd0) begin
         n_err++;
         $display("FAIL ovf_drain_count: got n=%0d level=%0d, want %0d 0", rxq.size(), level_o, DEPTH);
      end
      for (int i = 0; i < DEPTH && i < rxq.size(); i++) begin
         n_cmp++;
         if (rxq[i] !== {1'b0, data[i*8 +: 8]}) begin
            n_err++;
            $display("FAIL ovf_drain_byte%0d: got %h want %h", i, rxq[i], {1'b0, data[i*8 +: 8]});
         end
      end
      rxq.delete();
      send_packet(160'h77, 8, 160'd0);
      idle(3);
      exp_pkt++;
      n_cmp++;
      if (rxq.size() != 1 || rxq[0] !== 9'h177 || err_ovf_o !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_next_pkt: got n=%0d byte=%h ovf=%b, want n=1 177 1", rxq.size(), rxq[0], err_ovf_o);
      end
      ready_mode = 0;
   endtask

   task automatic test_full_pop();
      logic [159:0] fill;
      logic [7:0]   nb;
      fill = '0;
      for (int i = 0; i < DEPTH; i++) fill[i*8 +: 8] = 8'($urandom);
      nb = 8'h5A;
      pulse_clr();
      rxq.delete();
      ready_mode = 0;
      send_packet(fill, DEPTH * 8, 160'd0);
      idle(2);
      exp_pkt++;
      n_cmp++;
      if (level_o !== 5'(DEPTH) || err_ovf_o !== 1'b0) begin
         n_err++;
         $display("FAIL full_fill: level=%0d ovf=%b, want %0d 0", level_o, err_ovf_o, DEPTH);
      end
      for (int b = 0; b < 7; b++) drive_bit(1'b0, 1'b0, nb[b]);
      @(posedge clk); #1 ready_mode = 3;
      drive_bit(1'b1, 1'b0, nb[7]);
      drive_bit(1'b1, 1'b1, 1'b0);
      exp_pkt++;
      n_cmp++;
      if (level_o !== 5'(DEPTH) || err_ovf_o !== 1'b0 || rxq.size() != 1) begin
         n_err++;
         $display("FAIL full_push_pop: level=%0d ovf=%b popped=%0d, want %0d 0 1",
                  level_o, err_ovf_o, rxq.size(), DEPTH);
      end
      expq.delete();
      for (int i = 0; i < DEPTH; i++) expq.push_back({(i == DEPTH - 1), fill[i*8 +: 8]});
      expq.push_back({1'b1, nb});
      ready_mode = 1;
      idle(DEPTH + 4);
      n_cmp++;
      if (rxq.size() != expq.size()) begin
         n_err++;
         $display("FAIL full_drain_count: got %0d want %0d", rxq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
         n_cmp++;
         if (rxq[i] !== expq[i]) begin
            n_err++;
            $display("FAIL full_drain_byte%0d: got %h want %h", i, rxq[i], expq[i]);
         end
      end
      n_cmp++;
      if (pkt_cnt_o !== exp_cnt(exp_pkt)) begin
         n_err++;
         $display("FAIL full_pkt_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt(exp_pkt));
      end
      ready_mode = 0;
   endtask

   task automatic test_midreset();
      logic [15:0] junk;
      junk = 16'hFFFF;
      rxq.delete();
      ready_mode = 0;
      send_packet(160'hC3, 8, 160'd0);
      send_packet(160'h5, 3, 160'd0);
      idle(1);
      n_cmp++;
      if (level_o !== 5'd1 || err_frag_o !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_pre: level=%0d frag=%b, want 1 1", level_o, err_frag_o);
      end
      for (int b = 0; b < 5; b++) drive_bit(1'b0, 1'b0, junk[b]);
      drive_bit(1'b0, 1'b0, junk[5]);
      reset_n = 1'b0;
      drive_bit(1'b0, 1'b0, junk[6]);
      reset_n = 1'b1;
      exp_pkt = 0; exp_drop = 0;
      n_cmp++;
      if ({byte_o, byte_last_o, byte_valid_o, level_o, err_frag_o, err_ovf_o, pkt_cnt_o, drop_cnt_o} !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs: byte=%h valid=%b level=%0d frag=%b ovf=%b pkt=%0d drop=%0d, want all 0",
                  byte_o, byte_valid_o, level_o, err_frag_o, err_ovf_o, pkt_cnt_o, drop_cnt_o);
      end
      for (int b = 7; b < 16; b++) drive_bit((b == 15), 1'b0, junk[b]);
      idle(2);
      n_cmp++;
      if (level_o !== 5'd0 || err_frag_o !== 1'b0 || err_ovf_o !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_ignored: level=%0d frag=%b ovf=%b, want 0 0 0", level_o, err_frag_o, err_ovf_o);
      end
      ready_mode = 1;
      send_packet(160'h81, 8, 160'd0);
      idle(3);
      exp_pkt++;
      n_cmp++;
      if (rxq.size() != 1 || rxq[0] !== 9'h181 || pkt_cnt_o !== exp_cnt(exp_pkt)) begin
         n_err++;
         $display("FAIL midrst_next_pkt: got n=%0d byte=%h pkt=%0d, want n=1 181 %0d",
                  rxq.size(), rxq[0], pkt_cnt_o, exp_cnt(exp_pkt));
      end
      ready_mode = 0;
   endtask

   task automatic test_random();
      logic [159:0] data, bub;
      int nb, waited;
      rxq.delete();
      expq.delete();
      ready_mode = 2;
      for (int p = 0; p < 25; p++) begin
         nb   = $urandom_range(1, 4);
         data = {128'd0, 32'($urandom)};
         bub  = {128'd0, 32'($urandom & $urandom)};
         for (int i = 0; i < nb; i++) expq.push_back({(i == nb - 1), data[i*8 +: 8]});
         send_packet(data, nb * 8, bub);
         idle($urandom_range(0, 3));
         exp_pkt++;
      end
      ready_mode = 1;
      waited = 0;
      while (level_o !== 5'd0 && waited < 100) begin idle(1); waited++; end
      idle(2);
      n_cmp++;
      if (level_o !== 5'd0 || rxq.size() != expq.size()) begin
         n_err++;
         $display("FAIL rand_drain: level=%0d got n=%0d want n=%0d", level_o, rxq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
         n_cmp++;
         if (rxq[i] !== expq[i]) begin
            n_err++;
            $display("FAIL rand_byte%0d: got %h want %h", i, rxq[i], expq[i]);
         end
      end
      n_cmp++;
      if ({err_frag_o, err_ovf_o} !== 2'b00 || pkt_cnt_o !== exp_cnt(exp_pkt)) begin
         n_err++;
         $display("FAIL rand_status: frag=%b ovf=%b pkt=%0d, want 0 0 %0d",
                  err_frag_o, err_ovf_o, pkt_cnt_o, exp_cnt(exp_pkt));
      end
      ready_mode = 0;
   endtask

   initial begin
      test_reset();
      test_basic(160'd0, "basic");
      test_basic((160'd1 << 3) | (160'd1 << 11), "bubbles");
      test_frag();
      test_overflow();
      test_full_pop();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_err);
      $fatal(1);
   end

endmodule
